// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard unit: FSM state encoding,
// ALU forward-select codes and the register-match helper.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W_BITS = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DIV_BUSY = 2'b01,
    MEM_WAIT = 2'b10
  } state_e;

  localparam logic [FWD_W_BITS-1:0] FWD_RF = 2'b00;
  localparam logic [FWD_W_BITS-1:0] FWD_W  = 2'b01;
  localparam logic [FWD_W_BITS-1:0] FWD_M  = 2'b10;

  // r0 is hardwired to zero, so it never counts as a producer/consumer match
  function automatic logic reg_hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// ALU operand forward select for one source register; M stage beats W stage.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0]      src_i,
  input  logic [REG_W-1:0]      writereg_m_i,
  input  logic [REG_W-1:0]      writereg_w_i,
  input  logic                  regwrite_m_i,
  input  logic                  regwrite_w_i,
  output logic [FWD_W_BITS-1:0] sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (regwrite_m_i && reg_hit(src_i, writereg_m_i)) begin
      sel_o = FWD_M;
    end else if (regwrite_w_i && reg_hit(src_i, writereg_w_i)) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load/branch stalls and a divider/memory wait FSM.
// Optional MEM_WAIT watchdog enabled by defining HAZARD_TIMEOUT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_W-1:0]      rsD,
  input  logic [REG_W-1:0]      rtD,
  input  logic [REG_W-1:0]      rsE,
  input  logic [REG_W-1:0]      rtE,
  input  logic [REG_W-1:0]      writeregE,
  input  logic [REG_W-1:0]      writeregM,
  input  logic [REG_W-1:0]      writeregW,
  input  logic                  regwriteE,
  input  logic                  regwriteM,
  input  logic                  regwriteW,
  input  logic                  memtoregE,
  input  logic                  memtoregM,
  input  logic                  branchD,
  input  logic                  jrD,
  input  logic                  divE,
  input  logic                  div_ready,
  input  logic                  dmem_reqM,
  input  logic                  dmem_ack,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  stallE,
  output logic                  stallM,
  output logic                  stallW,
  output logic                  flushE,
  output logic                  flushM,
  output logic                  flushW,
  output logic                  forwardAD,
  output logic                  forwardBD,
  output logic [FWD_W_BITS-1:0] forwardAE,
  output logic [FWD_W_BITS-1:0] forwardBE,
  output logic                  div_start,
  output logic                  timeout_err
);

  state_e state_q, state_d;
  logic   lwstall, brstall, div_hold, mem_hold, div_go, fsm_hold;

  fwd_sel u_fwd_a (
    .src_i(rsE), .writereg_m_i(writeregM), .writereg_w_i(writeregW),
    .regwrite_m_i(regwriteM), .regwrite_w_i(regwriteW), .sel_o(forwardAE)
  );

  fwd_sel u_fwd_b (
    .src_i(rtE), .writereg_m_i(writeregM), .writereg_w_i(writeregW),
    .regwrite_m_i(regwriteM), .regwrite_w_i(regwriteW), .sel_o(forwardBE)
  );

  assign forwardAD = regwriteM && reg_hit(rsD, writeregM);
  assign forwardBD = regwriteM && reg_hit(rtD, writeregM);

  assign lwstall = memtoregE && (reg_hit(rtE, rsD) || reg_hit(rtE, rtD));
  assign brstall = (branchD || jrD) &&
                   ((regwriteE && (reg_hit(writeregE, rsD) || reg_hit(writeregE, rtD))) ||
                    (memtoregM && (reg_hit(writeregM, rsD) || reg_hit(writeregM, rtD))));

`ifdef HAZARD_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             tmo_hit;

  assign tmo_hit     = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
`ifdef HAZARD_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef HAZARD_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // The launching IDLE cycle already holds the pipeline like the target state
  always_comb begin
    state_d  = state_q;
    div_hold = 1'b0;
    mem_hold = 1'b0;
    div_go   = 1'b0;
`ifdef HAZARD_TIMEOUT_EN
    cnt_d    = '0;
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (dmem_reqM && !dmem_ack) begin
          state_d  = MEM_WAIT;
          mem_hold = 1'b1;
        end else if (divE) begin
          state_d  = DIV_BUSY;
          div_hold = 1'b1;
          div_go   = 1'b1;
        end
      end
      DIV_BUSY: begin
        div_hold = 1'b1;
        if (div_ready) state_d = IDLE;
      end
      MEM_WAIT: begin
        mem_hold = 1'b1;
        if (dmem_ack) begin
          state_d = IDLE;
`ifdef HAZARD_TIMEOUT_EN
        end else if (tmo_hit) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    fsm_hold  = div_hold || mem_hold;
    stallF    = !rst && (fsm_hold || lwstall || brstall);
    stallD    = !rst && (fsm_hold || lwstall || brstall);
    stallE    = !rst && fsm_hold;
    stallM    = !rst && mem_hold;
    stallW    = 1'b0;
    flushE    = !rst && !fsm_hold && (lwstall || brstall);
    flushM    = !rst && div_hold;
    flushW    = !rst && mem_hold;
    div_start = !rst && div_go;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares the full output vector.
module tb_hazard_ctrl;

  logic       clk, rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, jrD, divE, div_ready, dmem_reqM, dmem_ack;
  logic       stallF, stallD, stallE, stallM, stallW, flushE, flushM, flushW;
  logic       forwardAD, forwardBD, div_start, timeout_err;
  logic [1:0] forwardAE, forwardBE;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];
  logic [15:0] act;

  localparam logic [4:0] S_NO  = 5'b00000;
  localparam logic [4:0] S_LW  = 5'b11000;
  localparam logic [4:0] S_DIV = 5'b11100;
  localparam logic [4:0] S_MEM = 5'b11110;
  localparam logic [2:0] F_NO  = 3'b000;
  localparam logic [2:0] F_LW  = 3'b100;
  localparam logic [2:0] F_DIV = 3'b010;
  localparam logic [2:0] F_MEM = 3'b001;

  hazard_ctrl #(.TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .jrD(jrD), .divE(divE), .div_ready(div_ready),
    .dmem_reqM(dmem_reqM), .dmem_ack(dmem_ack),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .div_start(div_start), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {stallF, stallD, stallE, stallM, stallW, flushE, flushM, flushW,
                forwardAD, forwardBD, forwardAE, forwardBE, div_start, timeout_err};

  function automatic logic [15:0] mk(input logic [4:0] s, input logic [2:0] f,
                                     input logic [1:0] fd, input logic [1:0] fae,
                                     input logic [1:0] fbe, input logic ds, input logic te);
    return {s, f, fd, fae, fbe, ds, te};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got stlF/D/E/M/W flE/M/W fAD/BD fAE fBE ds te = %b, want %b", n, act, e);
      end
    end
  end

  // Inputs for this cycle are already applied; queue the expectation and advance
  task automatic chk(input string n, input logic [15:0] e);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
    {branchD, jrD, divE, div_ready, dmem_reqM, dmem_ack} = '0;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;

    // reset forces all stall/flush outputs low despite hazards
    memtoregE = 1; rtE = 8; rsD = 8; divE = 1; dmem_reqM = 1;
    chk("reset_hold", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b00, 0, 0));
    rst = 1'b0;
    clr();
    chk("idle_quiet", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b00, 0, 0));

    // forwarding priorities
    rsE = 5; rtE = 5; writeregM = 5; writeregW = 5; regwriteM = 1; regwriteW = 1;
    chk("fwd_m_prio", mk(S_NO, F_NO, 2'b00, 2'b10, 2'b10, 0, 0));
    regwriteM = 0;
    chk("fwd_w_only", mk(S_NO, F_NO, 2'b00, 2'b01, 2'b01, 0, 0));
    clr(); rsE = 0; writeregM = 0; regwriteM = 1; rtE = 7; writeregW = 7; regwriteW = 1;
    chk("fwd_r0_and_bw", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b01, 0, 0));
    clr(); rsD = 9; rtD = 0; writeregM = 9; regwriteM = 1;
    chk("fwd_ad", mk(S_NO, F_NO, 2'b10, 2'b00, 2'b00, 0, 0));

    // load-use stall, then forward from M
    clr(); memtoregE = 1; rtE = 8; writeregE = 8; regwriteE = 1; rsD = 8;
    chk("lw_stall", mk(S_LW, F_LW, 2'b00, 2'b00, 2'b00, 0, 0));
    clr(); rsE = 8; writeregM = 8; regwriteM = 1; memtoregM = 1;
    chk("lw_fwd_m", mk(S_NO, F_NO, 2'b00, 2'b10, 2'b00, 0, 0));
    clr(); memtoregE = 1; rtE = 3; rtD = 3;
    chk("lw_stall_rt", mk(S_LW, F_LW, 2'b00, 2'b00, 2'b00, 0, 0));
    clr(); memtoregE = 1; rtE = 0; rsD = 0;
    chk("lw_r0", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b00, 0, 0));

    // branch stalls
    clr(); branchD = 1; rsD = 4; regwriteE = 1; writeregE = 4;
    chk("br_stall_e", mk(S_LW, F_LW, 2'b00, 2'b00, 2'b00, 0, 0));
    clr(); branchD = 1; rtD = 12; memtoregM = 1; regwriteM = 1; writeregM = 12;
    chk("br_stall_m", mk(S_LW, F_LW, 2'b01, 2'b00, 2'b00, 0, 0));
    clr(); jrD = 1; rsD = 0; writeregE = 0; regwriteE = 1;
    chk("jr_r0", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b00, 0, 0));
    clr(); branchD = 1; rsD = 4; regwriteM = 1; writeregM = 4;
    chk("br_alu_m_fwd", mk(S_NO, F_NO, 2'b10, 2'b00, 2'b00, 0, 0));

    // divide: launch-cycle div_ready ignored, 7 stall cycles total
    clr(); divE = 1; div_ready = 1;
    chk("div_launch", mk(S_DIV, F_DIV, 2'b00, 2'b00, 2'b00, 1, 0));
    div_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) begin memtoregE = 1; rtE = 8; rsD = 8; end
      else begin memtoregE = 0; rtE = 0; rsD = 0; end
      chk($sformatf("div_busy%0d", i), mk(S_DIV, F_DIV, 2'b00, 2'b00, 2'b00, 0, 0));
    end
    div_ready = 1;
    chk("div_ready", mk(S_DIV, F_DIV, 2'b00, 2'b00, 2'b00, 0, 0));
    clr();
    chk("div_done", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b00, 0, 0));

    // memory wait wins over simultaneous divide
    clr(); dmem_reqM = 1; divE = 1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("mem_wait%0d", i), mk(S_MEM, F_MEM, 2'b00, 2'b00, 2'b00, 0, 0));
    dmem_ack = 1;
    chk("mem_ack", mk(S_MEM, F_MEM, 2'b00, 2'b00, 2'b00, 0, 0));
    clr();
    chk("mem_done", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b00, 0, 0));

    // reset in the middle of a divide aborts it
    clr(); divE = 1;
    chk("div2_launch", mk(S_DIV, F_DIV, 2'b00, 2'b00, 2'b00, 1, 0));
    chk("div2_busy1", mk(S_DIV, F_DIV, 2'b00, 2'b00, 2'b00, 0, 0));
    chk("div2_busy2", mk(S_DIV, F_DIV, 2'b00, 2'b00, 2'b00, 0, 0));
    rst = 1'b1;
    chk("div2_rst", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b00, 0, 0));
    divE = 0;
    rst = 1'b0;
    chk("div2_post_rst", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b00, 0, 0));
    divE = 1;
    chk("div3_launch", mk(S_DIV, F_DIV, 2'b00, 2'b00, 2'b00, 1, 0));
    divE = 0; div_ready = 1;
    chk("div3_ready", mk(S_DIV, F_DIV, 2'b00, 2'b00, 2'b00, 0, 0));
    clr();
    chk("div3_done", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b00, 0, 0));

    // long memory wait: watchdog fires after 10 wait cycles only when enabled
    clr(); dmem_reqM = 1;
    chk("tmo_launch", mk(S_MEM, F_MEM, 2'b00, 2'b00, 2'b00, 0, 0));
    for (int i = 1; i <= 10; i++)
      chk($sformatf("tmo_wait%0d", i), mk(S_MEM, F_MEM, 2'b00, 2'b00, 2'b00, 0, 0));
`ifdef HAZARD_TIMEOUT_EN
    dmem_reqM = 0;
    chk("tmo_idle", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b00, 0, 1));
    chk("tmo_sticky", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b00, 0, 1));
`else
    for (int i = 11; i <= 14; i++)
      chk($sformatf("tmo_wait%0d", i), mk(S_MEM, F_MEM, 2'b00, 2'b00, 2'b00, 0, 0));
    dmem_ack = 1;
    chk("tmo_ack", mk(S_MEM, F_MEM, 2'b00, 2'b00, 2'b00, 0, 0));
    clr();
    chk("tmo_done", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b00, 0, 0));
`endif
    rst = 1'b1;
    chk("final_rst", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b00, 0, 0));
    rst = 1'b0;
    chk("final_idle", mk(S_NO, F_NO, 2'b00, 2'b00, 2'b00, 0, 0));

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning maximum MEM_WAIT cycles before the watchdog fires (used only with HAZARD_TIMEOUT_EN).
REQ-002 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rsD, rtD, rsE, rtE  input  5 each  source register numbers in Decode and Execute.
REQ-005 writeregE, writeregM, writeregW  input  5 each  destination register per stage.
REQ-006 regwriteE, regwriteM, regwriteW, memtoregE, memtoregM  input  1 each  controller pipeline flags.
REQ-007 branchD, jrD  input  1 each  Decode-stage branch / jump-register.
REQ-008 divE  input  1  multi-cycle divide in Execute; div_ready  input  1  divider result valid.
REQ-009 dmem_reqM  input  1  data-memory access in Memory stage; dmem_ack  input  1  memory completion.
REQ-010 stallF, stallD, stallE, stallM, stallW  output  1 each  stage hold.
REQ-011 flushE, flushM, flushW  output  1 each  bubble insert into the named stage register.
REQ-012 forwardAD, forwardBD  output  1 each  Decode comparator forward from M.
REQ-013 forwardAE, forwardBE  output  2 each  ALU operand select: 00 regfile, 01 W result, 10 M result.
REQ-014 div_start  output  1  one-cycle divider launch pulse.
REQ-015 timeout_err  output  1  sticky watchdog flag.

Function
REQ-016 Register 0 SHALL never match for forwarding or stall comparisons.
REQ-017 forwardAE SHALL be 10 when rsE matches writeregM with regwriteM, else 01 when rsE matches writeregW with regwriteW, else 00; forwardBE identical using rtE; M has priority over W.
REQ-018 forwardAD/BD SHALL be 1 when rsD/rtD matches writeregM with regwriteM.
REQ-019 lwstall SHALL be memtoregE and (rtE==rsD or rtE==rtD).
REQ-020 brstall SHALL be (branchD or jrD) and ((regwriteE and writeregE matches rsD/rtD) or (memtoregM and writeregM matches rsD/rtD)).
REQ-021 On lwstall or brstall in IDLE: stallF=stallD=1, flushE=1, all others 0.
REQ-022 FSM states IDLE, DIV_BUSY, MEM_WAIT (2-bit encoding).
REQ-023 IDLE->MEM_WAIT when dmem_reqM and not dmem_ack; IDLE->DIV_BUSY when divE (and no memory wait); memory wait wins if simultaneous.
REQ-024 div_start SHALL pulse exactly one cycle, in the IDLE cycle where the DIV_BUSY transition is taken.
REQ-025 DIV_BUSY: stallF/D/E=1, flushM=1; returns to IDLE the cycle after div_ready is sampled high; div_ready in the launch cycle is ignored.
REQ-026 MEM_WAIT: stallF/D/E/M=1, flushW=1; returns to IDLE the cycle after dmem_ack is sampled high.
REQ-027 FSM stalls SHALL override lwstall/brstall; flushE SHALL be 0 while any FSM stall is active.
REQ-028 Forwarding outputs SHALL remain live (combinational) in every state.

Reset
REQ-029 While rst high: state IDLE, wait counter 0, timeout_err 0, div_start 0, all stall and flush outputs 0 regardless of inputs.
REQ-030 Reset mid DIV_BUSY/MEM_WAIT SHALL abort immediately; no div_start on release unless divE is re-presented.

Configuration
REQ-031 With HAZARD_TIMEOUT_EN defined: an 8-bit counter increments each MEM_WAIT cycle; on reaching TIMEOUT_CYCLES the FSM returns to IDLE and timeout_err sets and stays set until reset.
REQ-032 Without HAZARD_TIMEOUT_EN: no counter, MEM_WAIT waits indefinitely, timeout_err tied 0.

Structure
REQ-033 State encoding and forward-select constants (FWD_RF, FWD_W, FWD_M) SHALL live in shared package hazard_pkg.
REQ-034 Forward-select logic SHALL be one sub-module fwd_sel, instantiated for A and B operands.

Verification
REQ-035 lw writes r8 in E, D reads rs=8 -> stallF=stallD=flushE=1 one cycle, then forwardAE=10 next cycle.
REQ-036 rsE=5 matches writeregM=5 and writeregW=5, both regwrite -> forwardAE=10; rsE=0 with writeregM=0 -> 00.
REQ-037 divE=1 in IDLE, div_ready high 6 cycles later -> div_start pulses once, stallF/D/E=1 for 7 cycles, then 0.
REQ-038 dmem_reqM=1, dmem_ack after 3 cycles, divE=1 same cycle -> MEM_WAIT first, stallM=1 4 cycles, no div_start during wait.
REQ-039 HAZARD_TIMEOUT_EN, TIMEOUT_CYCLES=10, dmem_ack never -> IDLE after 10 wait cycles, timeout_err=1 until rst.
REQ-040 rst asserted in DIV_BUSY cycle 3 -> all stalls 0 same cycle, IDLE after release.
